// File: rtl/reg_issue_ctrl.sv
// rtl/reg_issue_ctrl.sv - four-state issue/writeback controller for the register block
// Optional R0_HARDWIRE_EN: suppress the write-back of any instruction whose rd is 0.
module reg_issue_ctrl #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int IMM_IN = 15,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [RWIDTH-1:0] rs,
  output logic [RWIDTH-1:0] rt,
  output logic [RWIDTH-1:0] rd,
  output logic [IMM_IN-1:0] imm_in,
  output logic              muxsel1,
  output logic [3:0]        ALUopsel,
  input  logic [DWIDTH-1:0] ALUresult,
  output logic [DWIDTH-1:0] wd,
  output logic              we,
  output logic              done,
  output logic [CNTW-1:0]   retire_cnt
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  localparam logic [3:0] OP_NOP = 4'b1111;

  state_t state;
  logic   wb_write;

  assign instr_ready = (state == IDLE);

`ifdef R0_HARDWIRE_EN
  assign wb_write = (ALUopsel != OP_NOP) && (rd != '0);
`else
  assign wb_write = (ALUopsel != OP_NOP);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rs         <= '0;
      rt         <= '0;
      rd         <= '0;
      imm_in     <= '0;
      muxsel1    <= 1'b0;
      ALUopsel   <= OP_NOP;
      wd         <= '0;
      we         <= 1'b0;
      done       <= 1'b0;
      retire_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ALUopsel <= instr[31:28];
            muxsel1  <= instr[27];
            rd       <= instr[26:21];
            rs       <= instr[20:15];
            rt       <= instr[14:9];
            imm_in   <= instr[14:0];
            state    <= DECODE;
          end
        end
        DECODE: state <= EXEC;
        EXEC: begin
          // we/done are registered so they are high exactly for the WB cycle
          wd    <= ALUresult;
          we    <= wb_write;
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          we         <= 1'b0;
          done       <= 1'b0;
          retire_cnt <= retire_cnt + {{(CNTW-1){1'b0}}, 1'b1};
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_issue_ctrl.sv
// tb/tb_reg_issue_ctrl.sv - directed self-checking bench for reg_issue_ctrl (CNTW = 4)
module tb_reg_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  rs, rt, rd;
  logic [14:0] imm_in;
  logic        muxsel1;
  logic [3:0]  ALUopsel;
  logic [31:0] ALUresult;
  logic [31:0] wd;
  logic        we;
  logic        done;
  logic [3:0]  retire_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_issue_ctrl #(.RWIDTH(6), .DWIDTH(32), .IMM_IN(15), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs(rs), .rt(rt), .rd(rd), .imm_in(imm_in), .muxsel1(muxsel1),
    .ALUopsel(ALUopsel), .ALUresult(ALUresult), .wd(wd), .we(we), .done(done),
    .retire_cnt(retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present w at a negedge, let it be accepted, return at the DECODE-cycle negedge.
  task automatic issue(input logic [31:0] w);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic run_nop();
    issue({4'hF, 1'b0, 6'd9, 6'd1, 6'd2, 9'd0});
    repeat (3) @(negedge clk);
  endtask

  logic [11:0] rdy_hist;
  int acc, wec, dnc;
  int acc_cyc [2];
  logic expect_r0_we;

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    ALUresult = '0;
`ifdef R0_HARDWIRE_EN
    expect_r0_we = 1'b0;
`else
    expect_r0_we = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("reset_ready", instr_ready, 1);
    chk("reset_opsel", ALUopsel, 4'hF);
    chk("reset_we", we, 0);
    chk("reset_cnt", retire_cnt, 0);
    chk("reset_rd", rd, 0);
    rst = 1'b0;
    @(negedge clk);

    // register ADD
    ALUresult = 32'hBBBBAAAA;
    issue({4'b0000, 1'b0, 6'h3F, 6'h07, 6'h38, 9'h0});
    chk("add_rs", rs, 7);
    chk("add_rt", rt, 56);
    chk("add_mux", muxsel1, 0);
    chk("add_ready", instr_ready, 0);
    @(negedge clk);
    chk("add_exec_we", we, 0);
    @(negedge clk);
    chk("add_wb_we", we, 1);
    chk("add_wb_rd", rd, 63);
    chk("add_wb_wd", wd, 32'hBBBBAAAA);
    chk("add_wb_done", done, 1);
    @(negedge clk);
    chk("add_cnt", retire_cnt, 1);
    chk("add_idle_we", we, 0);
    chk("add_idle_ready", instr_ready, 1);

    // immediate SUB
    ALUresult = 32'h0000A001;
    issue({4'b0011, 1'b1, 6'h33, 6'h07, 15'h0AA9});
    chk("sub_mux", muxsel1, 1);
    chk("sub_imm", imm_in, 15'h0AA9);
    chk("sub_opsel", ALUopsel, 3);
    chk("sub_rt", rt, 5);
    repeat (2) @(negedge clk);
    chk("sub_wb_we", we, 1);
    chk("sub_wb_rd", rd, 51);
    chk("sub_wb_wd", wd, 32'h0000A001);
    @(negedge clk);
    chk("sub_cnt", retire_cnt, 2);

    // back-to-back with instr_valid held high
    ALUresult = 32'h12345678;
    acc = 0; wec = 0; rdy_hist = '0;
    instr = {4'b0000, 1'b0, 6'd5, 6'd1, 6'd2, 9'd0};
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rdy_hist[c] = instr_ready;
      if (we) wec++;
      if (instr_valid && instr_ready) begin
        if (acc < 2) acc_cyc[acc] = c;
        acc++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc == 1) instr = {4'b0010, 1'b0, 6'd6, 6'd3, 6'd4, 9'd0};
      if (acc >= 2) instr_valid = 1'b0;
    end
    chk("b2b_accepts", acc, 2);
    chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 4);
    chk("b2b_ready_hist", rdy_hist, 12'hF11);
    chk("b2b_we_pulses", wec, 2);
    chk("b2b_last_rd", rd, 6);
    chk("b2b_cnt", retire_cnt, 4);

    // NOP
    wec = 0; dnc = 0;
    instr = {4'hF, 1'b0, 6'd9, 6'd1, 6'd2, 9'd0};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (we) wec++;
      if (done) dnc++;
      @(negedge clk);
    end
    chk("nop_we_pulses", wec, 0);
    chk("nop_done_pulses", dnc, 1);
    chk("nop_cnt", retire_cnt, 5);

    // counter to 15, then one more retire wraps to 0 (ADD to r0)
    repeat (10) run_nop();
    chk("cnt_15", retire_cnt, 15);
    ALUresult = 32'hCAFEF00D;
    issue({4'b0000, 1'b0, 6'd0, 6'd1, 6'd2, 9'd0});
    repeat (2) @(negedge clk);
    chk("r0_done", done, 1);
    chk("r0_we", we, {31'd0, expect_r0_we});
    chk("r0_wd", wd, 32'hCAFEF00D);
    @(negedge clk);
    chk("cnt_wrap", retire_cnt, 0);

    // reset in the middle of EXEC
    run_nop();
    chk("pre_rst_cnt", retire_cnt, 1);
    ALUresult = 32'h55555555;
    issue({4'b0000, 1'b0, 6'd10, 6'd1, 6'd2, 9'd0});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_we", we, 0);
    chk("rst_opsel", ALUopsel, 4'hF);
    chk("rst_ready", instr_ready, 1);
    chk("rst_cnt", retire_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    wec = 0; dnc = 0;
    for (int c = 0; c < 5; c++) begin
      if (we) wec++;
      if (done) dnc++;
      @(negedge clk);
    end
    chk("post_rst_we", wec, 0);
    chk("post_rst_done", dnc, 0);
    chk("post_rst_cnt", retire_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_issue_ctrl.md
Name: reg_issue_ctrl

Overview:
- Multi-cycle issue/writeback controller that drives the register block's operand, immediate, ALU-select and write ports.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it into rs/rt/rd/imm_in/muxsel1/ALUopsel.
- Samples the register block's ALUresult and writes it back through wd/we/rd.
- Acts as the controller that is the other end of the register block interface; it replaces the hand-driven stimulus used up to now.

Parameters:
- RWIDTH, 6, register address width
- DWIDTH, 32, data width
- IMM_IN, 15, immediate field width
- CNTW, 16, width of the retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction present on instr
- instr_ready  output  1  controller can accept an instruction
- instr  input  32  instruction word
- rs  output  RWIDTH  operand A register address
- rt  output  RWIDTH  operand B register address
- rd  output  RWIDTH  destination register address
- imm_in  output  IMM_IN  immediate to register block
- muxsel1  output  1  0 = opB from rt, 1 = opB from imm_in
- ALUopsel  output  4  ALU operation select
- ALUresult  input  DWIDTH  result from register block ALU
- wd  output  DWIDTH  write-back data
- we  output  1  register file write enable
- done  output  1  one-cycle pulse when an instruction retires
- retire_cnt  output  CNTW  count of retired instructions

Behaviour:
- Instruction format:
  - instr[31:28] = ALUopsel
  - instr[27] = muxsel1
  - instr[26:21] = rd
  - instr[20:15] = rs
  - instr[14:9] = rt
  - instr[14:0] = imm
  - When muxsel1 = 1, the rt field is still driven but is don't-care to the register block.
- States: IDLE, DECODE, EXEC, WB.
- Reset, asynchronous, takes effect immediately including mid-operation:
  - State goes to IDLE.
  - rs = rt = rd = 0, imm_in = 0, muxsel1 = 0, ALUopsel = 4'b1111, wd = 0, we = 0, done = 0, retire_cnt = 0.
  - Any in-flight instruction is discarded with no write.
- instr_ready = 1 only in IDLE; it is combinational from state, so it is 1 while in reset.
- IDLE -> DECODE when instr_valid & instr_ready at a rising edge. instr is captured into the field registers on that edge. instr_valid while not ready is ignored; the source must hold it.
- DECODE (cycle 1 after accept):
  - Field outputs are stable.
  - The register block reads combinationally.
  - Go to EXEC.
- EXEC (cycle 2): ALUresult is captured into wd at the end of the cycle. Go to WB.
- WB (cycle 3):
  - we = 1 for exactly this cycle, with rd and wd stable.
  - done = 1.
  - retire_cnt increments at the end of the cycle, wrapping modulo 2^CNTW.
  - Go to IDLE.
- NOP: ALUopsel == 4'b1111 follows the same path, but we stays 0 in WB. done still pulses and retire_cnt still increments.
- Latency: accept edge to the WB cycle = 3 cycles. Sustained throughput is one instruction per 4 cycles.
- Field outputs hold their last values in IDLE, with ALUopsel held, so the register block sees stable addresses. we is 0 in every state except WB.
- rd may equal rs or rt: the write occurs after the read has been captured, so no hazard inside one instruction.
- Back-to-back instructions see the previous write because WB precedes the next DECODE.

Optional Feature:
- Macro R0_HARDWIRE_EN.
- When defined: any instruction with rd == 0 suppresses we in WB (wd is still updated). done and retire_cnt behave normally. Register 0 therefore stays at its reset content.
- When undefined: rd == 0 is written like any other register.

Test Plan:
- Reset check: assert rst mid-EXEC of an ADD -> same cycle: we = 0, ALUopsel = 4'b1111, instr_ready = 1. After release, no write occurs and retire_cnt = 0.
- Register ADD: instr = {4'b0000, 1'b0, 6'h3F, 6'h07, 6'h38, 9'h0}, bench models ALUresult = 32'hBBBBAAAA -> rs = 7 and rt = 56 from the cycle after accept. In WB: we = 1, rd = 63, wd = 32'hBBBBAAAA, done = 1. retire_cnt = 1.
- Immediate SUB: instr = {4'b0011, 1'b1, 6'h33, 6'h07, 15'h0AA9}, bench ALUresult = 32'h0000A001 -> muxsel1 = 1, imm_in = 15'h0AA9. In WB: rd = 51, wd = 32'h0000A001, we = 1.
- Handshake/backpressure:
  - Hold instr_valid high with two different instructions back-to-back -> instr_ready low for 3 cycles after each accept.
  - The second instruction is accepted exactly 4 cycles after the first.
  - Exactly two we pulses occur.
- NOP: instr with ALUopsel = 4'b1111 -> no we pulse, done pulses once, retire_cnt increments.
- Counter wrap and R0: preload retire_cnt via 65535 NOPs, or use CNTW = 4 with 15 NOPs, then retire one more -> retire_cnt = 0.
  - With R0_HARDWIRE_EN, an ADD to rd = 0 gives done = 1 and we = 0.
  - Without R0_HARDWIRE_EN, the same ADD gives we = 1.
